alu_32_bit_cmd_sequencer: RTL and testbench
===========================================

// Module: alu_32_bit_cmd_sequencer
//
// PURPOSE
// - Upstream issue/capture stage for the combinational ALU_32_Bit. Accepts one command
//   (opcode, A, B) over a valid/ready handshake and drives the ALU's enable, select and
//   operand inputs.
// - Samples Result_Out/Carry_Out after a fixed settle time and returns a registered
//   response over a second valid/ready handshake.
// - Screens out divide/modulo by zero before the ALU sees it. Counts completed responses.
//
// PARAMETERS
// - DATA_WIDTH   32   operand/result width; must match the ALU (32)
// - EXEC_CYCLES  1    cycles ALU_Enable_Out is held before sampling; >=1
// - COUNT_WIDTH  16   width of the completed-response counter
//
// PORTS
// - Clock_In                 in   1            single clock, rising edge
// - Reset_n_In               in   1            asynchronous, active-low reset
// - Cmd_Valid_In             in   1            command present
// - Cmd_Ready_Out            out  1            sequencer can accept a command
// - Cmd_Op_In                in   4            ALU opcode 0x0..0xF (ALU encoding)
// - Cmd_A_In                 in   DATA_WIDTH   operand A
// - Cmd_B_In                 in   DATA_WIDTH   operand B
// - ALU_Enable_Out           out  1            to ALU Enable_In
// - ALU_Operation_Select_Out out  4            to ALU ALU_Operation_Select_In
// - ALU_Data_A_Out           out  DATA_WIDTH   to ALU Data_A_In
// - ALU_Data_B_Out           out  DATA_WIDTH   to ALU Data_B_In
// - ALU_Result_In            in   DATA_WIDTH   from ALU Result_Out
// - ALU_Carry_In             in   1            from ALU Carry_Out
// - Rsp_Valid_Out            out  1            response present
// - Rsp_Ready_In             in   1            consumer accepts response
// - Rsp_Result_Out           out  DATA_WIDTH   registered result
// - Rsp_Carry_Out            out  1            registered carry
// - Rsp_Div_Zero_Out         out  1            op 6/7 issued with B==0
// - Rsp_Count_Out            out  COUNT_WIDTH  responses handed off since reset
//
// BEHAVIOUR
// - Reset: state IDLE; Cmd_Ready_Out=1 while in reset; all other outputs 0; counter 0.
// - FSM IDLE: Cmd_Ready_Out=1. Cmd_Valid_In&&Cmd_Ready_Out at edge k latches op/A/B onto
//   the ALU_* outputs. Then:
//   - op in {6,7} and B==0 -> RESP at k+1 with Result=0, Carry=0, Div_Zero=1.
//     ALU_Enable_Out never asserts for this command.
//   - otherwise -> EXEC.
// - FSM EXEC: ALU_Enable_Out=1 for exactly EXEC_CYCLES cycles. At the last edge
//   (k+EXEC_CYCLES), capture ALU_Result_In/ALU_Carry_In, Div_Zero=0, go to RESP.
// - FSM RESP: Rsp_Valid_Out=1 and all Rsp_* fields stable until Rsp_Ready_In. On the
//   handshake edge: Rsp_Count_Out++ (wraps 2^COUNT_WIDTH-1 -> 0), go to IDLE.
// - Cmd_Ready_Out=0 in EXEC and RESP. No new command in the same cycle as the response
//   handshake; next accept is one cycle later at the earliest.
// - ALU_Enable_Out=0 outside EXEC. ALU_Result_In is never sampled while enable is low
//   (the ALU drives Z then). ALU_Data_*/select outputs hold the last latched values.
// - Latency accept->Rsp_Valid: EXEC_CYCLES edges (1 edge for div-by-zero).
//   Throughput: at most 1 command per EXEC_CYCLES+2 cycles.
// - Reset asserted mid-operation: immediate async return to reset values; the in-flight
//   command is dropped and no response is issued.
// - Width: result is the ALU's low DATA_WIDTH bits; carry is the ALU's bit DATA_WIDTH,
//   passed through unchanged.
//
// CONFIGURATION
// - ALU_SEQ_ACCUM_EN defined:
//   - adds input Cmd_Accum_In (1). Accum register resets to 0 and loads Rsp_Result_Out
//     on each response handshake.
//   - Cmd_Accum_In=1 at accept uses the accum register as A instead of Cmd_A_In.
//   - The div-zero screen still applies; a div-zero response loads 0 into accum.
// - Not defined: no Cmd_Accum_In port and no accum register; A is always Cmd_A_In.
//
// TESTING (EXEC_CYCLES=1)
// - Reset: hold Reset_n_In=0 -> Cmd_Ready_Out=1, Rsp_Valid_Out=0, ALU_Enable_Out=0,
//   Rsp_Count_Out=0.
// - Add: op=2, A=0xFFFFFFFF, B=0x1, Rsp_Ready_In=1 -> Rsp_Valid_Out one edge after accept;
//   Result=0x00000000, Carry=1, Div_Zero=0, Count=1.
// - Div-zero: op=6, A=0x10, B=0 -> Result=0, Carry=0, Div_Zero=1; ALU_Enable_Out stays 0.
//   Repeat with op=7 -> same response.
// - Backpressure: op=8, A=0xF0F0F0F0, B=0xFF00FF00, Rsp_Ready_In=0 for 5 cycles ->
//   Result=0xF000F000 held stable and Cmd_Ready_Out=0 throughout; second command waits,
//   is accepted one cycle after the handshake; Count=1 then 2.
// - Mid-op reset: accept op=5, assert reset during EXEC -> no Rsp_Valid_Out, Count=0,
//   Cmd_Ready_Out=1 after release.
// - ALU_SEQ_ACCUM_EN: op=0, A=5 -> 6; then op=2, Accum=1, B=10 -> 16 (A drives 6);
//   then op=6, Accum=1, B=0 -> Div_Zero=1, accum becomes 0.

Source files
------------

// File: rtl/alu_32_bit_cmd_sequencer_if.sv
// Command/response handshake bundle for alu_32_bit_cmd_sequencer.
// Optional macro ALU_SEQ_ACCUM_EN adds the Cmd_Accum_In select line.
interface alu_32_bit_cmd_sequencer_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
);
   logic                   Cmd_Valid_In;
   logic                   Cmd_Ready_Out;
   logic [3:0]             Cmd_Op_In;
   logic [DATA_WIDTH-1:0]  Cmd_A_In;
   logic [DATA_WIDTH-1:0]  Cmd_B_In;
`ifdef ALU_SEQ_ACCUM_EN
   logic                   Cmd_Accum_In;
`endif
   logic                   Rsp_Valid_Out;
   logic                   Rsp_Ready_In;
   logic [DATA_WIDTH-1:0]  Rsp_Result_Out;
   logic                   Rsp_Carry_Out;
   logic                   Rsp_Div_Zero_Out;
   logic [COUNT_WIDTH-1:0] Rsp_Count_Out;

   modport master (
`ifdef ALU_SEQ_ACCUM_EN
      output Cmd_Accum_In,
`endif
      output Cmd_Valid_In,
      output Cmd_Op_In,
      output Cmd_A_In,
      output Cmd_B_In,
      output Rsp_Ready_In,
      input  Cmd_Ready_Out,
      input  Rsp_Valid_Out,
      input  Rsp_Result_Out,
      input  Rsp_Carry_Out,
      input  Rsp_Div_Zero_Out,
      input  Rsp_Count_Out
   );

   modport slave (
`ifdef ALU_SEQ_ACCUM_EN
      input  Cmd_Accum_In,
`endif
      input  Cmd_Valid_In,
      input  Cmd_Op_In,
      input  Cmd_A_In,
      input  Cmd_B_In,
      input  Rsp_Ready_In,
      output Cmd_Ready_Out,
      output Rsp_Valid_Out,
      output Rsp_Result_Out,
      output Rsp_Carry_Out,
      output Rsp_Div_Zero_Out,
      output Rsp_Count_Out
   );
endinterface

// File: rtl/alu_32_bit_cmd_sequencer.sv
// Issue/capture sequencer in front of the combinational ALU_32_Bit.
// Optional macro ALU_SEQ_ACCUM_EN enables the accumulator-as-A feature.
module alu_32_bit_cmd_sequencer #(
   parameter int DATA_WIDTH  = 32,
   parameter int EXEC_CYCLES = 1,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                  Clock_In,
   input  logic                  Reset_n_In,
   alu_32_bit_cmd_sequencer_if.slave bus,
   output logic                  ALU_Enable_Out,
   output logic [3:0]            ALU_Operation_Select_Out,
   output logic [DATA_WIDTH-1:0] ALU_Data_A_Out,
   output logic [DATA_WIDTH-1:0] ALU_Data_B_Out,
   input  logic [DATA_WIDTH-1:0] ALU_Result_In,
   input  logic                  ALU_Carry_In
);

   localparam int CNT_W =
      (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] EXEC_LAST =
      CNT_W'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DZERO,
      EXEC,
      RESP
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       exec_cnt;
   logic                   cmd_ready;
   logic                   rsp_valid;
   logic [DATA_WIDTH-1:0]  rsp_result;
   logic                   rsp_carry;
   logic                   rsp_dz;
   logic [COUNT_WIDTH-1:0] rsp_count;
   logic [DATA_WIDTH-1:0]  a_sel;
   logic                   accept;
   logic                   div_zero;

`ifdef ALU_SEQ_ACCUM_EN
   logic [DATA_WIDTH-1:0]  accum;
   assign a_sel = bus.Cmd_Accum_In ? accum : bus.Cmd_A_In;
`else
   assign a_sel = bus.Cmd_A_In;
`endif

   assign accept   = bus.Cmd_Valid_In && cmd_ready;
   assign div_zero = ((bus.Cmd_Op_In == 4'h6) ||
                      (bus.Cmd_Op_In == 4'h7)) &&
                     (bus.Cmd_B_In == '0);

   assign bus.Cmd_Ready_Out    = cmd_ready;
   assign bus.Rsp_Valid_Out    = rsp_valid;
   assign bus.Rsp_Result_Out   = rsp_result;
   assign bus.Rsp_Carry_Out    = rsp_carry;
   assign bus.Rsp_Div_Zero_Out = rsp_dz;
   assign bus.Rsp_Count_Out    = rsp_count;

   // Command FSM: accept, run ALU or screen div-zero, hold response
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state                    <= IDLE;
         exec_cnt                 <= '0;
         cmd_ready                <= 1'b1;
         ALU_Enable_Out           <= 1'b0;
         ALU_Operation_Select_Out <= '0;
         ALU_Data_A_Out           <= '0;
         ALU_Data_B_Out           <= '0;
         rsp_valid                <= 1'b0;
         rsp_result               <= '0;
         rsp_carry                <= 1'b0;
         rsp_dz                   <= 1'b0;
         rsp_count                <= '0;
`ifdef ALU_SEQ_ACCUM_EN
         accum                    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  ALU_Operation_Select_Out <= bus.Cmd_Op_In;
                  ALU_Data_A_Out           <= a_sel;
                  ALU_Data_B_Out           <= bus.Cmd_B_In;
                  cmd_ready                <= 1'b0;
                  exec_cnt                 <= '0;
                  if (div_zero) begin
                     state          <= DZERO;
                  end else begin
                     ALU_Enable_Out <= 1'b1;
                     state          <= EXEC;
                  end
               end
            end
            DZERO: begin
               rsp_result <= '0;
               rsp_carry  <= 1'b0;
               rsp_dz     <= 1'b1;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            EXEC: begin
               if (exec_cnt == EXEC_LAST) begin
                  ALU_Enable_Out <= 1'b0;
                  rsp_result     <= ALU_Result_In;
                  rsp_carry      <= ALU_Carry_In;
                  rsp_dz         <= 1'b0;
                  rsp_valid      <= 1'b1;
                  state          <= RESP;
               end else begin
                  exec_cnt <= exec_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (bus.Rsp_Ready_In) begin
                  rsp_valid <= 1'b0;
                  rsp_count <= rsp_count + COUNT_WIDTH'(1);
`ifdef ALU_SEQ_ACCUM_EN
                  accum     <= rsp_result;
`endif
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_32_bit_cmd_sequencer.sv
// Directed bench for alu_32_bit_cmd_sequencer with a small ALU model.
// Build with ALU_SEQ_ACCUM_EN to also exercise the accumulator path.
module tb_alu_32_bit_cmd_sequencer;

   logic        clk;
   logic        rst_n;
   logic        alu_en;
   logic [3:0]  alu_sel;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic        alu_cy;
   int          total;
   int          bad;
   int          exp_cnt;

   alu_32_bit_cmd_sequencer_if #(
      .DATA_WIDTH(32),
      .COUNT_WIDTH(16)
   ) bus ();

   alu_32_bit_cmd_sequencer #(
      .DATA_WIDTH(32),
      .EXEC_CYCLES(1),
      .COUNT_WIDTH(16)
   ) dut (
      .Clock_In(clk),
      .Reset_n_In(rst_n),
      .bus(bus),
      .ALU_Enable_Out(alu_en),
      .ALU_Operation_Select_Out(alu_sel),
      .ALU_Data_A_Out(alu_a),
      .ALU_Data_B_Out(alu_b),
      .ALU_Result_In(alu_res),
      .ALU_Carry_In(alu_cy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in; junk while disabled so stray sampling shows up
   always_comb begin
      logic [32:0] r;
      r = {1'b1, 32'hDEAD_BEEF};
      if (alu_en) begin
         case (alu_sel)
            4'h0: r = {1'b0, alu_a} + 33'd1;
            4'h2: r = {1'b0, alu_a} + {1'b0, alu_b};
            4'h5: r = {1'b0, alu_a} - {1'b0, alu_b};
            4'h6: r = (alu_b == 0) ? '1 : {1'b0, alu_a / alu_b};
            4'h7: r = (alu_b == 0) ? '1 : {1'b0, alu_a % alu_b};
            4'h8: r = {1'b0, alu_a & alu_b};
            default: r = {1'b0, alu_a ^ alu_b};
         endcase
      end
      alu_res = r[31:0];
      alu_cy  = r[32];
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        acc;
      logic [31:0] exp_a;
      logic [31:0] res;
      logic        cy;
      logic        dz;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_cmd(input vec_t v);
      int lat;
      bit en_seen;
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b1;
      bus.Cmd_Op_In    = v.op;
      bus.Cmd_A_In     = v.a;
      bus.Cmd_B_In     = v.b;
      bus.Rsp_Ready_In = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
      bus.Cmd_Accum_In = v.acc;
`endif
      @(negedge clk);
      chk("cmd_ready_idle", bus.Cmd_Ready_Out, 1);
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b0;
      chk("alu_sel", alu_sel, v.op);
      chk("alu_a", alu_a, v.exp_a);
      chk("alu_b", alu_b, v.b);
      lat = 0;
      en_seen = 0;
      while (!bus.Rsp_Valid_Out && lat < 10) begin
         if (alu_en) en_seen = 1;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, 1);
      chk("enable_seen", en_seen, !v.dz);
      chk("result", bus.Rsp_Result_Out, v.res);
      chk("carry", bus.Rsp_Carry_Out, v.cy);
      chk("div_zero", bus.Rsp_Div_Zero_Out, v.dz);
      chk("ready_in_resp", bus.Cmd_Ready_Out, 0);
      chk("enable_in_resp", alu_en, 0);
      @(posedge clk); #1;
      exp_cnt++;
      chk("count", bus.Rsp_Count_Out, exp_cnt);
      chk("valid_after_hs", bus.Rsp_Valid_Out, 0);
      chk("ready_after_hs", bus.Cmd_Ready_Out, 1);
   endtask

   initial begin
      int n;
      total   = 0;
      bad     = 0;
      exp_cnt = 0;
      vecs[0] = '{4'h2, 32'hFFFF_FFFF, 32'h1, 0,
                  32'hFFFF_FFFF, 32'h0, 1, 0};
      vecs[1] = '{4'h6, 32'h10, 32'h0, 0,
                  32'h10, 32'h0, 0, 1};
      vecs[2] = '{4'h7, 32'h10, 32'h0, 0,
                  32'h10, 32'h0, 0, 1};
      vecs[3] = '{4'h8, 32'hF0F0_F0F0, 32'hFF00_FF00, 0,
                  32'hF0F0_F0F0, 32'hF000_F000, 0, 0};
      vecs[4] = '{4'h0, 32'h5, 32'h0, 0,
                  32'h5, 32'h6, 0, 0};
      vecs[5] = '{4'h6, 32'd100, 32'd7, 0,
                  32'd100, 32'd14, 0, 0};
      vecs[6] = '{4'h7, 32'd100, 32'd7, 0,
                  32'd100, 32'd2, 0, 0};

      rst_n            = 1'b0;
      bus.Cmd_Valid_In = 1'b0;
      bus.Cmd_Op_In    = '0;
      bus.Cmd_A_In     = '0;
      bus.Cmd_B_In     = '0;
      bus.Rsp_Ready_In = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
      bus.Cmd_Accum_In = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", bus.Cmd_Ready_Out, 1);
      chk("rst_valid", bus.Rsp_Valid_Out, 0);
      chk("rst_enable", alu_en, 0);
      chk("rst_count", bus.Rsp_Count_Out, 0);
      chk("rst_result", bus.Rsp_Result_Out, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) do_cmd(vecs[i]);

      // backpressure with a second command waiting
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b1;
      bus.Cmd_Op_In    = 4'h8;
      bus.Cmd_A_In     = 32'hF0F0_F0F0;
      bus.Cmd_B_In     = 32'hFF00_FF00;
      bus.Rsp_Ready_In = 1'b0;
      @(posedge clk); #1;
      chk("bp_ready_exec", bus.Cmd_Ready_Out, 0);
      bus.Cmd_Op_In = 4'h2;
      bus.Cmd_A_In  = 32'h1;
      bus.Cmd_B_In  = 32'h2;
      n = 0;
      while (!bus.Rsp_Valid_Out && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", n, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_result", bus.Rsp_Result_Out, 32'hF000_F000);
         chk("bp_valid", bus.Rsp_Valid_Out, 1);
         chk("bp_ready", bus.Cmd_Ready_Out, 0);
      end
      chk("bp_sel_held", alu_sel, 4'h8);
      @(posedge clk); #1;
      bus.Rsp_Ready_In = 1'b1;
      @(posedge clk); #1;
      exp_cnt++;
      chk("bp_count1", bus.Rsp_Count_Out, exp_cnt);
      chk("bp_valid_hs", bus.Rsp_Valid_Out, 0);
      chk("bp_ready_hs", bus.Cmd_Ready_Out, 1);
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b0;
      chk("bp2_accepted", bus.Cmd_Ready_Out, 0);
      chk("bp2_sel", alu_sel, 4'h2);
      chk("bp2_a", alu_a, 32'h1);
      n = 0;
      while (!bus.Rsp_Valid_Out && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp2_latency", n, 1);
      chk("bp2_result", bus.Rsp_Result_Out, 32'h3);
      @(posedge clk); #1;
      exp_cnt++;
      chk("bp_count2", bus.Rsp_Count_Out, exp_cnt);

      // reset while the ALU is running
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b1;
      bus.Cmd_Op_In    = 4'h5;
      bus.Cmd_A_In     = 32'h9;
      bus.Cmd_B_In     = 32'h4;
      @(posedge clk); #1;
      bus.Cmd_Valid_In = 1'b0;
      chk("mid_enable", alu_en, 1);
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("mid_rst_ready", bus.Cmd_Ready_Out, 1);
      chk("mid_rst_enable", alu_en, 0);
      chk("mid_rst_valid", bus.Rsp_Valid_Out, 0);
      chk("mid_rst_count", bus.Rsp_Count_Out, exp_cnt);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_no_rsp", bus.Rsp_Valid_Out, 0);
      end
      chk("mid_ready", bus.Cmd_Ready_Out, 1);
      chk("mid_count", bus.Rsp_Count_Out, 0);

`ifdef ALU_SEQ_ACCUM_EN
      do_cmd('{4'h0, 32'h5, 32'h0, 0,
               32'h5, 32'h6, 0, 0});
      do_cmd('{4'h2, 32'h999, 32'd10, 1,
               32'h6, 32'd16, 0, 0});
      do_cmd('{4'h6, 32'h77, 32'h0, 1,
               32'd16, 32'h0, 0, 1});
      do_cmd('{4'h0, 32'h55, 32'h0, 1,
               32'h0, 32'h1, 0, 0});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
